// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one memory op, runs a single outstanding
// access on the 64-bit data port, and returns extended load data or a store ack.
module lsu_ctrl #(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_load,
  input  logic              mem_wen,
  input  logic [3:0]        wdt_op,
  input  logic              is_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wmask,
  output logic [63:0]       mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [7:0]        wmask_q, wmask_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [2:0]        off_q, off_d;
  logic [3:0]        wdt_q, wdt_d;
  logic              uns_q, uns_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [7:0]  byte_mask;
  logic [63:0] lane_mask;
  logic        misaligned;
  logic        illegal;
  logic [63:0] rd_shifted;
  logic [63:0] load_data;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    byte_mask  = 8'h00;
    misaligned = 1'b0;
    case (wdt_op)
      4'b0001: byte_mask = 8'h01;
      4'b0010: begin byte_mask = 8'h03; misaligned = addr[0];      end
      4'b0100: begin byte_mask = 8'h0F; misaligned = |addr[1:0];   end
      4'b1000: begin byte_mask = 8'hFF; misaligned = |addr[2:0];   end
      default: ;
    endcase
    lane_mask = '0;
    for (int i = 0; i < 8; i++) lane_mask[8*i +: 8] = {8{byte_mask[i]}};
    illegal = (is_load == mem_wen) || (wdt_op == 4'b0000) ||
              ((wdt_op & (wdt_op - 4'd1)) != 4'b0000);
  end

  always_comb begin
    rd_shifted = mem_rdata >> {off_q, 3'b000};
    load_data  = '0;
    case (wdt_q)
      4'b0001: load_data = uns_q ? {56'b0, rd_shifted[7:0]}  : {{56{rd_shifted[7]}},  rd_shifted[7:0]};
      4'b0010: load_data = uns_q ? {48'b0, rd_shifted[15:0]} : {{48{rd_shifted[15]}}, rd_shifted[15:0]};
      4'b0100: load_data = uns_q ? {32'b0, rd_shifted[31:0]} : {{32{rd_shifted[31]}}, rd_shifted[31:0]};
      4'b1000: load_data = rd_shifted;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    wdt_d   = wdt_q;
    uns_d   = uns_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        addr_d  = {addr[ADDR_W-1:3], 3'b000};
        we_d    = mem_wen;
        wmask_d = mem_wen ? (byte_mask << addr[2:0]) : 8'h00;
        wdata_d = (wdata & lane_mask) << {addr[2:0], 3'b000};
        off_d   = addr[2:0];
        wdt_d   = wdt_op;
        uns_d   = is_unsigned;
        rdata_d = '0;
        err_d   = illegal || misaligned;
        state_d = (illegal || misaligned) ? S_RESP : S_REQ;
      end
      S_REQ: if (mem_req_ready) begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response on the final counted cycle still beats the timeout.
        if (mem_rsp_valid) begin
          rdata_d = we_q ? 64'h0 : load_data;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wmask_q <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      wdt_q   <= '0;
      uns_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      wdt_q   <= wdt_d;
      uns_q   <= uns_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign resp_valid    = (state_q == S_RESP);
  assign mem_addr      = addr_q;
  assign mem_we        = we_q;
  assign mem_wmask     = wmask_q;
  assign mem_wdata     = wdata_q;
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table for single transactions plus
// hand-written backpressure, timeout and reset sequences.
module tb_lsu_ctrl;
  localparam int AW = 64;
  localparam int TO = 20;
  localparam int TW = 8;

  logic          clk, rst_n;
  logic          req_valid, req_ready;
  logic          is_load, mem_wen, is_unsigned;
  logic [3:0]    wdt_op;
  logic [AW-1:0] addr;
  logic [63:0]   wdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [63:0]   resp_rdata;
  logic          mem_req_valid, mem_req_ready, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wmask;
  logic [63:0]   mem_wdata;
  logic          mem_rsp_valid;
  logic [63:0]   mem_rdata;

  lsu_ctrl #(.ADDR_W(AW), .TIMEOUT(TO), .TO_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .mem_wen(mem_wen), .wdt_op(wdt_op), .is_unsigned(is_unsigned),
    .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_mem_hs = 0;
  int n_resp_hs = 0;

  always @(posedge clk) begin
    if (mem_req_valid && mem_req_ready) n_mem_hs++;
    if (resp_valid && resp_ready) n_resp_hs++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ld, st;
    logic [3:0]  wdt;
    logic        uns;
    logic [63:0] addr, wdata, mrdata;
    logic [63:0] e_maddr;
    logic        e_we;
    logic [7:0]  e_wmask;
    logic [63:0] e_wdata, e_rdata;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(input logic ld, input logic st, input logic [3:0] wdt,
                              input logic uns, input logic [63:0] a, input logic [63:0] wd,
                              input logic [63:0] mrd, input logic [7:0] wm,
                              input logic [63:0] ewd, input logic [63:0] erd, input logic err);
    vec_t v;
    v.ld = ld; v.st = st; v.wdt = wdt; v.uns = uns;
    v.addr = a; v.wdata = wd; v.mrdata = mrd;
    v.e_maddr = {a[63:3], 3'b000};
    v.e_we = st; v.e_wmask = wm; v.e_wdata = ewd; v.e_rdata = erd; v.e_err = err;
    return v;
  endfunction

  task automatic check_mem(input vec_t v, input string tag);
    check({tag, " mem_req_valid"}, 64'(mem_req_valid), 64'd1);
    check({tag, " mem_addr"}, mem_addr, v.e_maddr);
    check({tag, " mem_we"}, 64'(mem_we), 64'(v.e_we));
    check({tag, " mem_wmask"}, 64'(mem_wmask), 64'(v.e_wmask));
    check({tag, " mem_wdata"}, mem_wdata, v.e_wdata);
    check({tag, " req_ready busy"}, 64'(req_ready), 64'd0);
  endtask

  task automatic check_resp(input vec_t v, input string tag);
    check({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
    check({tag, " resp_rdata"}, resp_rdata, v.e_rdata);
    check({tag, " resp_err"}, 64'(resp_err), 64'(v.e_err));
    check({tag, " req_ready resp"}, 64'(req_ready), 64'd0);
  endtask

  task automatic drive_req(input vec_t v);
    is_load = v.ld; mem_wen = v.st; wdt_op = v.wdt; is_unsigned = v.uns;
    addr = v.addr; wdata = v.wdata; mem_rdata = v.mrdata;
    req_valid = 1'b1;
  endtask

  // Runs one transaction; all sampling and driving happens on the falling edge.
  task automatic run_vec(input vec_t v, input int rq_stall, input int rs_stall, input string tag);
    int mem_before;
    mem_before = n_mem_hs;
    @(negedge clk);
    check({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
    drive_req(v);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    if (v.e_err) begin
      check({tag, " no mem_req"}, 64'(mem_req_valid), 64'd0);
      check_resp(v, tag);
    end else begin
      check_mem(v, tag);
      for (int i = 0; i < rq_stall; i++) begin
        @(negedge clk);
        check_mem(v, {tag, " stall"});
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      check({tag, " wait no req"}, 64'(mem_req_valid), 64'd0);
      check({tag, " wait no resp"}, 64'(resp_valid), 64'd0);
      mem_rsp_valid = 1'b1;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      check_resp(v, tag);
    end
    for (int i = 0; i < rs_stall; i++) begin
      @(negedge clk);
      check_resp(v, {tag, " rstall"});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, " resp dropped"}, 64'(resp_valid), 64'd0);
    check({tag, " req_ready back"}, 64'(req_ready), 64'd1);
    check({tag, " mem handshakes"}, 64'(n_mem_hs - mem_before), v.e_err ? 64'd0 : 64'd1);
  endtask

  localparam logic [63:0] RD  = 64'h1122_3344_8566_7788;
  localparam logic [63:0] WD  = 64'h1234_5678_DEAD_BEEF;
  localparam logic [63:0] JNK = 64'hFFFF_FFFF_FFFF_FFFF;

  vec_t vecs[17];
  vec_t tv;
  int   resp_before;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //                ld    st    wdt      uns   addr                  wdata mrdata wmask  exp_wdata                exp_rdata                err
    vecs[0]  = mk(1'b1, 1'b0, 4'b0001, 1'b0, 64'h8000_0003, 64'h0, RD,  8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF85, 1'b0); // lb
    vecs[1]  = mk(1'b1, 1'b0, 4'b0001, 1'b1, 64'h8000_0003, 64'h0, RD,  8'h00, 64'h0, 64'h0000_0000_0000_0085, 1'b0); // lbu
    vecs[2]  = mk(1'b0, 1'b1, 4'b0100, 1'b0, 64'h8000_0004, WD,    JNK, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0, 1'b0); // sw
    vecs[3]  = mk(1'b1, 1'b0, 4'b0010, 1'b0, 64'h8000_0002, 64'h0, RD,  8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8566, 1'b0); // lh
    vecs[4]  = mk(1'b1, 1'b0, 4'b0010, 1'b1, 64'h8000_0002, 64'h0, RD,  8'h00, 64'h0, 64'h0000_0000_0000_8566, 1'b0); // lhu
    vecs[5]  = mk(1'b1, 1'b0, 4'b0010, 1'b0, 64'h8000_0006, 64'h0, RD,  8'h00, 64'h0, 64'h0000_0000_0000_1122, 1'b0); // lh +
    vecs[6]  = mk(1'b1, 1'b0, 4'b0100, 1'b0, 64'h8000_0000, 64'h0, RD,  8'h00, 64'h0, 64'hFFFF_FFFF_8566_7788, 1'b0); // lw
    vecs[7]  = mk(1'b1, 1'b0, 4'b0100, 1'b1, 64'h8000_0000, 64'h0, RD,  8'h00, 64'h0, 64'h0000_0000_8566_7788, 1'b0); // lwu
    vecs[8]  = mk(1'b1, 1'b0, 4'b1000, 1'b0, 64'h8000_0008, 64'h0, 64'h8000_0000_0000_0001, 8'h00, 64'h0, 64'h8000_0000_0000_0001, 1'b0); // ld
    vecs[9]  = mk(1'b0, 1'b1, 4'b0001, 1'b0, 64'h8000_0007, WD,    JNK, 8'h80, 64'hEF00_0000_0000_0000, 64'h0, 1'b0); // sb
    vecs[10] = mk(1'b0, 1'b1, 4'b0010, 1'b0, 64'h8000_0002, WD,    JNK, 8'h0C, 64'h0000_0000_BEEF_0000, 64'h0, 1'b0); // sh
    vecs[11] = mk(1'b0, 1'b1, 4'b1000, 1'b0, 64'h8000_0010, WD,    JNK, 8'hFF, WD, 64'h0, 1'b0);                      // sd
    vecs[12] = mk(1'b1, 1'b0, 4'b0010, 1'b0, 64'h8000_0001, 64'h0, RD,  8'h00, 64'h0, 64'h0, 1'b1); // lh misaligned
    vecs[13] = mk(1'b1, 1'b1, 4'b0001, 1'b0, 64'h8000_0000, 64'h0, RD,  8'h00, 64'h0, 64'h0, 1'b1); // load+store
    vecs[14] = mk(1'b1, 1'b0, 4'b0011, 1'b0, 64'h8000_0000, 64'h0, RD,  8'h00, 64'h0, 64'h0, 1'b1); // not one-hot
    vecs[15] = mk(1'b0, 1'b0, 4'b0100, 1'b0, 64'h8000_0000, 64'h0, RD,  8'h00, 64'h0, 64'h0, 1'b1); // neither
    vecs[16] = mk(1'b0, 1'b1, 4'b1000, 1'b0, 64'h8000_0004, WD,    RD,  8'h00, 64'h0, 64'h0, 1'b1); // sd misaligned

    rst_n = 1'b0; req_valid = 1'b0; is_load = 1'b0; mem_wen = 1'b0; wdt_op = 4'b0;
    is_unsigned = 1'b0; addr = '0; wdata = '0; resp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    #12;
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("reset resp_valid", 64'(resp_valid), 64'd0);
    check("reset outputs", {mem_addr[31:0], mem_wdata[15:0], mem_wmask, 6'b0, mem_we, resp_err},
          64'd0);
    check("reset resp_rdata", resp_rdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) run_vec(vecs[i], 0, 0, $sformatf("vec%0d", i));

    // Backpressure on both sides of a store.
    resp_before = n_resp_hs;
    run_vec(vecs[2], 5, 3, "bp");
    check("bp one response", 64'(n_resp_hs - resp_before), 64'd1);

    // Timeout: no response ever arrives.
    tv = mk(1'b1, 1'b0, 4'b1000, 1'b0, 64'h8000_0008, 64'h0, RD, 8'h00, 64'h0, 64'h0, 1'b1);
    @(negedge clk);
    drive_req(tv);
    @(negedge clk);
    req_valid = 1'b0;
    check_mem(tv, "to");
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      check($sformatf("to wait%0d", i), 64'(resp_valid), 64'd0);
      @(negedge clk);
    end
    check_resp(tv, "to");
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    repeat (2) @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("late rsp ignored valid", 64'(resp_valid), 64'd0);
    check("late rsp ignored ready", 64'(req_ready), 64'd1);

    // Response on the final counted WAIT cycle wins over the timeout.
    tv = mk(1'b1, 1'b0, 4'b1000, 1'b0, 64'h8000_0008, 64'h0, RD, 8'h00, 64'h0, RD, 1'b0);
    @(negedge clk);
    drive_req(tv);
    @(negedge clk);
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      check($sformatf("edge wait%0d", i), 64'(resp_valid), 64'd0);
      if (i == TO - 1) mem_rsp_valid = 1'b1;
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0;
    check_resp(tv, "edge");
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Asynchronous reset in the middle of WAIT.
    tv = mk(1'b1, 1'b0, 4'b1000, 1'b0, 64'h8000_0008, 64'h0, RD, 8'h00, 64'h0, RD, 1'b0);
    @(negedge clk);
    drive_req(tv);
    @(negedge clk);
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst req_ready", 64'(req_ready), 64'd1);
    check("arst mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("arst resp_valid", 64'(resp_valid), 64'd0);
    check("arst mem_addr", mem_addr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("stale rsp ignored", 64'(resp_valid), 64'd0);
    run_vec(vecs[8], 0, 0, "post-reset ld");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
